// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for decode, then steps pc (seq/branch/jump).
// Latency: ins_valid rises the cycle after imem_ack; best case one instruction every 2 cycles.
// Backpressure: holds ins_out/pc_out while ins_ready=0; keeps imem_addr stable while imem_ack=0.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  - instruction memory request/response handshake
//   ins_out/valid/ready      - held instruction to decode, with its byte address on pc_out
//   jump, jump_target        - consumed instruction is j; target field instr[25:0]
//   branch_taken/offset      - consumed beq resolved taken; sign-extended word offset
//   fetch_count              - instructions consumed since reset (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc_out,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] ins_q;
  logic [31:0] pc_out_q;
  logic [31:0] count_q;
  logic [31:0] next_pc;
  logic        take_ins;
  logic        consume;

  // Response is accepted only while fetching; acks seen in HOLD are dropped.
  assign take_ins = (state == FETCH) && imem_ack;
  assign consume  = (state == HOLD) && ins_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (imem_ack)  state_nxt = HOLD;
      HOLD:  if (ins_ready) state_nxt = FETCH;
      default:              state_nxt = FETCH;
    endcase
  end

  // Output logic; rst masks the handshakes combinationally so they read 0
  // for the whole reset window, not just after the first reset edge.
  always_comb begin
    imem_req  = 1'b0;
    ins_valid = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:   imem_req  = 1'b1;
        HOLD:    ins_valid = 1'b1;
        default: imem_req  = 1'b0;
      endcase
    end
  end

  // Next fetch address from the instruction being consumed; jump wins over branch.
  always_comb begin
    if (jump) begin
      next_pc = {pc_out_q[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_out_q + 32'd4 + (branch_offset << 2);
    end else begin
      next_pc = pc_out_q + 32'd4;
    end
  end

  // Datapath: pc only moves on consume, so imem_addr is stable across wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ins_q    <= 32'h0000_0000;
      pc_out_q <= RESET_PC;
      count_q  <= 32'h0000_0000;
    end else begin
      if (take_ins) begin
        ins_q    <= imem_rdata;
        pc_out_q <= pc;
      end
      if (consume) begin
        pc      <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_addr   = pc;
  assign ins_out     = ins_q;
  assign pc_out      = pc_out_q;
  assign fetch_count = count_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: imem_addr  output  32  byte address of the requested instruction.
REQ-006 SHALL have port: imem_ack  input  1  memory returns data this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port: ins_out  output  32  held instruction presented to decode/control.
REQ-009 SHALL have port: ins_valid  output  1  ins_out is valid.
REQ-010 SHALL have port: ins_ready  input  1  decode consumes ins_out this cycle.
REQ-011 SHALL have port: pc_out  output  32  byte address of ins_out.
REQ-012 SHALL have port: jump  input  1  consumed instruction is j.
REQ-013 SHALL have port: jump_target  input  26  instr[25:0] of the consumed j.
REQ-014 SHALL have port: branch_taken  input  1  consumed beq resolved taken (Branch AND zero).
REQ-015 SHALL have port: branch_offset  input  32  sign-extended beq immediate.
REQ-016 SHALL have port: fetch_count  output  32  number of instructions consumed since reset.

Function
REQ-017 SHALL implement a two-state FSM: FETCH and HOLD.
REQ-018 In FETCH, SHALL drive imem_req=1, imem_addr=pc, ins_valid=0.
REQ-019 SHALL keep imem_addr stable while imem_req=1 and imem_ack=0, for unbounded wait cycles.
REQ-020 In FETCH with imem_ack=1: ins_out<=imem_rdata, pc_out<=pc, next state HOLD.
REQ-021 In HOLD, SHALL drive imem_req=0 and ins_valid=1, with ins_out and pc_out stable.
REQ-022 In HOLD with ins_ready=0, SHALL remain in HOLD indefinitely and ignore jump, branch_taken and imem_ack.
REQ-023 In HOLD with ins_ready=1: fetch_count increments by 1, pc<=next_pc, next state FETCH.
REQ-024 next_pc SHALL be {pc_out[31:28], jump_target, 2'b00} when jump=1.
REQ-025 next_pc SHALL otherwise be pc_out + 4 + (branch_offset << 2) when branch_taken=1.
REQ-026 next_pc SHALL otherwise be pc_out + 4.
REQ-027 jump SHALL have priority over branch_taken when both are 1.
REQ-028 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles (1-cycle ack, ready held high).
REQ-031 imem_ack while in HOLD SHALL be ignored and SHALL NOT overwrite ins_out.
REQ-032 imem_rdata SHALL be sampled only on the cycle imem_ack=1 in FETCH.

Reset
REQ-033 While rst=1 at posedge clk: pc<=RESET_PC, state<=FETCH, ins_out<=0, pc_out<=RESET_PC, fetch_count<=0.
REQ-034 While rst=1, imem_req and ins_valid SHALL read 0.
REQ-035 The first request (imem_addr=RESET_PC) SHALL assert the first cycle after rst deasserts.
REQ-036 rst SHALL override any in-flight wait or HOLD state; an imem_ack coincident with rst SHALL be discarded.

Verification
REQ-037 Test reset then sequential fetch: rst 2 cycles, ack every request with 1-cycle latency, ready=1 -> imem_addr sequence 0,4,8,12; fetch_count=3 after third consume.
REQ-038 Test memory wait: ack delayed 5 cycles at addr 8 -> imem_addr held at 8 for all 5 cycles; ins_valid=0 until the cycle after ack.
REQ-039 Test decode stall: ready=0 for 4 cycles in HOLD with ins_out=32'h2149_0004 -> ins_out, pc_out unchanged; imem_req=0; count unchanged.
REQ-040 Test branch: pc_out=20, branch_taken=1, offset=1 at consume -> next imem_addr=28; offset=32'hFFFF_FFFA from pc_out 28 -> next imem_addr=8.
REQ-041 Test jump priority: pc_out=32'h4000_0028, jump=1, jump_target=26'h7, branch_taken=1 -> next imem_addr=32'h4000_001C.
REQ-042 Test reset mid-operation: rst asserted during an outstanding request with coincident imem_ack -> ins_valid=0, fetch_count=0, next imem_addr=RESET_PC.
